wbsplit2: RTL and testbench
===========================

Name: wbsplit2

Overview:
- One-master-to-two-slave Wishbone (pipelined, B4) address-decoding splitter.
- It is the counterpart to the two-master arbiter. The arbiter merges masters onto one bus; this block fans one master out to two slave regions. It routes ack/err back to the master and answers unmapped addresses with err.
- Sits between the AXI-Lite-to-WB bridge output and the I2C core / CSR slaves.

Parameters:
- AW, 32, address width
- DW, 32, data width
- S0_BASE, 32'h0000_0000, slave 0 base address (AW bits)
- S0_MASK, 32'hFFFF_F000, slave 0 match mask
- S1_BASE, 32'h0000_1000, slave 1 base address
- S1_MASK, 32'hFFFF_F000, slave 1 match mask
- LGDEPTH, 3, log2 of the maximum number of outstanding requests
- TIMEOUT, 15, watchdog cycle count (used only with the optional feature)

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_cyc, i_stb, i_we  in  1 each  master request
- i_adr  in  AW  master address
- i_dat  in  DW  master write data
- i_sel  in  DW/8  master byte select
- o_ack, o_stall, o_err  out  1 each  master response
- o_data  out  DW  master read data
- o_s0_cyc, o_s0_stb  out  1 each  slave 0 request
- i_s0_ack, i_s0_stall, i_s0_err  in  1 each  slave 0 response
- i_s0_data  in  DW  slave 0 read data
- o_s1_cyc, o_s1_stb  out  1 each  slave 1 request
- i_s1_ack, i_s1_stall, i_s1_err  in  1 each  slave 1 response
- i_s1_data  in  DW  slave 1 read data
- o_we, o_adr, o_dat, o_sel  out  1/AW/DW/DW/8  shared to both slaves; pass-through of the master fields

Behaviour:
- Decode (combinational): dec0 = ((i_adr & S0_MASK) == S0_BASE). dec1 likewise. If both match, slave 0 wins. If neither matches, the request is unmapped (NONE).
- State registers, all reset to 0 by async assert of i_reset_n:
  - r_sel (0/1/NONE, 2 bits)
  - r_cnt (LGDEPTH+1 bits, outstanding count)
  - r_err_pend
- Accept = i_cyc && i_stb && !o_stall.
- Stall conditions:
  - o_stall = 1 if r_cnt != 0 and dec != r_sel (different target while requests are outstanding).
  - o_stall = 1 if r_cnt == 2^LGDEPTH (full).
  - o_stall = 1 if r_err_pend.
  - Otherwise o_stall = the selected slave's stall.
  - An unmapped request is never slave-stalled.
- Request routing:
  - o_sN_stb = i_cyc && i_stb && dec==N && !blocked. "Blocked" means the first three stall conditions above.
  - o_sN_cyc = i_cyc && (r_cnt != 0 ? r_sel == N : dec == N).
- On accept to slave N: r_sel <= N; r_cnt increments unless an ack/err arrives in the same cycle, in which case r_cnt is held.
- On accept of an unmapped request (only possible when r_cnt == 0): r_err_pend <= 1; o_err = 1 exactly one cycle later; r_err_pend then clears.
- Response routing:
  - o_ack = (r_cnt != 0) && ack of r_sel.
  - o_data = data of r_sel.
  - Slave acks arriving when r_cnt == 0 are dropped.
- Slave err: o_err = 1 the same cycle, r_cnt <= 0, and o_sN_cyc drops the next cycle.
- Master i_cyc low: r_cnt <= 0, r_err_pend <= 0; no response is produced for that cycle.
- Reset mid-transaction: all slave cyc/stb outputs go low immediately (combinational via the cleared r_cnt/i_cyc path). o_ack, o_err and o_stall are 0 after reset.
- Latency: zero added cycles for mapped requests; one cycle for the unmapped err.

Optional Feature:
- Macro: WBSPLIT_TIMEOUT_EN.
- With the macro defined:
  - A down-counter reloads to TIMEOUT on each accept or ack, and decrements while r_cnt != 0.
  - On reaching 0: assert o_err for one cycle, clear r_cnt, force o_sN_cyc low for one cycle.
- Without the macro: no counter; a hung slave stalls the master indefinitely.

Decomposition:
- Package wbsplit_pkg holds:
  - typedef slave_sel_t enum {SEL_S0, SEL_S1, SEL_NONE}
  - the default base/mask constants
  - a decode function returning slave_sel_t
- Sub-module: none for the routing; the optional watchdog is a natural sub-module, wbsplit_watchdog.

Test Plan:
- Single read at 0x0000_0004, slave 0 acks at +2 cycles with data 0xDEADBEEF -> o_s0_cyc/stb asserted, o_ack one cycle later with o_data = 0xDEADBEEF; s1 idle.
- Pipelined 3 writes to slave 1 (0x1000, 0x1004, 0x1008), no stall -> r_cnt reaches 3, then returns to 0 after 3 acks; master sees 3 acks.
- Request to slave 0 while 2 slave-1 requests are outstanding -> o_stall = 1 until the second s1 ack, then the s0 stb is issued the next cycle.
- Access to 0x0000_8000 (unmapped) -> neither slave stb; o_err = 1 exactly one cycle after accept; o_ack = 0.
- Nine back-to-back requests with slave 1 never acking (LGDEPTH = 3) -> the 9th is stalled. With WBSPLIT_TIMEOUT_EN: o_err 15 cycles after the last accept, and o_s1_cyc low for one cycle.
- i_reset_n low while 2 requests are outstanding -> o_s1_cyc, o_ack, o_err = 0 immediately; after release, a new request routes normally.

Source files
------------

// File: rtl/wbsplit_pkg.sv
// wbsplit_pkg: shared slave-select type, default address map and decode helper for wbsplit2
package wbsplit_pkg;

    typedef enum logic [1:0] {
        SEL_S0   = 2'd0,
        SEL_S1   = 2'd1,
        SEL_NONE = 2'd2
    } slave_sel_t;

    localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_S0_MASK = 32'hFFFF_F000;
    localparam logic [31:0] DEF_S1_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_F000;

    function automatic slave_sel_t decode(input logic [63:0] adr, input logic [63:0] b0,
                                          input logic [63:0] m0, input logic [63:0] b1,
                                          input logic [63:0] m1);
        return ((adr & m0) == b0) ? SEL_S0 : ((adr & m1) == b1) ? SEL_S1 : SEL_NONE;
    endfunction

endpackage

// File: rtl/wbsplit_watchdog.sv
// wbsplit_watchdog: reloadable down-counter flagging a slave that stops answering (built only with WBSPLIT_TIMEOUT_EN)
`ifdef WBSPLIT_TIMEOUT_EN
module wbsplit_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_reload,
    input  logic i_active,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_expire = i_active && cnt_q == CW'(1);

    // Reload on any progress, otherwise count down while requests are outstanding
    always_comb cnt_d = i_reload ? CW'(TIMEOUT) : (i_active && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    // Counter register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
endmodule
`endif

// File: rtl/wbsplit2.sv
// wbsplit2: one-master to two-slave pipelined Wishbone splitter; define WBSPLIT_TIMEOUT_EN to add a hung-slave watchdog
module wbsplit2 import wbsplit_pkg::*; #(
    parameter int              AW      = 32,
    parameter int              DW      = 32,
    parameter logic [AW-1:0]   S0_BASE = AW'(DEF_S0_BASE),
    parameter logic [AW-1:0]   S0_MASK = AW'(DEF_S0_MASK),
    parameter logic [AW-1:0]   S1_BASE = AW'(DEF_S1_BASE),
    parameter logic [AW-1:0]   S1_MASK = AW'(DEF_S1_MASK),
    parameter int              LGDEPTH = 3,
    parameter int              TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_cyc,
    input  logic            i_stb,
    input  logic            i_we,
    input  logic [AW-1:0]   i_adr,
    input  logic [DW-1:0]   i_dat,
    input  logic [DW/8-1:0] i_sel,
    output logic            o_ack,
    output logic            o_stall,
    output logic            o_err,
    output logic [DW-1:0]   o_data,
    output logic            o_s0_cyc,
    output logic            o_s0_stb,
    input  logic            i_s0_ack,
    input  logic            i_s0_stall,
    input  logic            i_s0_err,
    input  logic [DW-1:0]   i_s0_data,
    output logic            o_s1_cyc,
    output logic            o_s1_stb,
    input  logic            i_s1_ack,
    input  logic            i_s1_stall,
    input  logic            i_s1_err,
    input  logic [DW-1:0]   i_s1_data,
    output logic            o_we,
    output logic [AW-1:0]   o_adr,
    output logic [DW-1:0]   o_dat,
    output logic [DW/8-1:0] o_sel
);
    localparam logic [LGDEPTH:0] FULL = {1'b1, {LGDEPTH{1'b0}}};

    slave_sel_t       dec, r_sel_q, r_sel_d;
    logic [LGDEPTH:0] r_cnt_q, r_cnt_d;
    logic             r_err_pend_q, r_err_pend_d;
    logic             live, busy, blocked, slv_stall, sel_ack, sel_err, accept, acc_map, wd_expire;

    assign dec       = decode(64'(i_adr), 64'(S0_BASE), 64'(S0_MASK), 64'(S1_BASE), 64'(S1_MASK));
    assign live      = i_reset_n && i_cyc;
    assign busy      = r_cnt_q != '0;
    assign blocked   = (busy && dec != r_sel_q) || r_cnt_q == FULL || r_err_pend_q || wd_expire;
    assign slv_stall = dec == SEL_S0 ? i_s0_stall : dec == SEL_S1 ? i_s1_stall : 1'b0;
    assign sel_ack   = busy && (r_sel_q == SEL_S1 ? i_s1_ack : i_s0_ack);
    assign sel_err   = busy && (r_sel_q == SEL_S1 ? i_s1_err : i_s0_err);
    assign accept    = live && i_stb && !blocked && !slv_stall;
    assign acc_map   = accept && dec != SEL_NONE;

    assign o_stall  = i_reset_n && (blocked || slv_stall);
    assign o_ack    = live && sel_ack;
    assign o_err    = live && (r_err_pend_q || sel_err || wd_expire);
    assign o_data   = r_sel_q == SEL_S1 ? i_s1_data : i_s0_data;
    assign o_s0_cyc = live && !wd_expire && (busy ? r_sel_q == SEL_S0 : dec == SEL_S0);
    assign o_s1_cyc = live && !wd_expire && (busy ? r_sel_q == SEL_S1 : dec == SEL_S1);
    assign o_s0_stb = live && i_stb && dec == SEL_S0 && !blocked;
    assign o_s1_stb = live && i_stb && dec == SEL_S1 && !blocked;
    assign o_we     = i_we;
    assign o_adr    = i_adr;
    assign o_dat    = i_dat;
    assign o_sel    = i_sel;

`ifdef WBSPLIT_TIMEOUT_EN
    wbsplit_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_reload  (acc_map || sel_ack),
        .i_active  (busy && i_cyc),
        .o_expire  (wd_expire)
    );
`else
    logic unused_timeout;
    assign wd_expire      = 1'b0;
    assign unused_timeout = TIMEOUT == 0;
`endif

    // Latch the target on a mapped accept, track outstanding requests, flag unmapped accepts
    always_comb begin
        r_sel_d      = acc_map ? dec : r_sel_q;
        r_err_pend_d = accept && dec == SEL_NONE;
        r_cnt_d      = (!live || sel_err || wd_expire) ? '0 :
                       (acc_map && !sel_ack)           ? r_cnt_q + 1'b1 :
                       (!acc_map && sel_ack)           ? r_cnt_q - 1'b1 : r_cnt_q;
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sel_q      <= SEL_S0;
            r_cnt_q      <= '0;
            r_err_pend_q <= 1'b0;
        end else begin
            r_sel_q      <= r_sel_d;
            r_cnt_q      <= r_cnt_d;
            r_err_pend_q <= r_err_pend_d;
        end
    end
endmodule

// File: tb/tb_wbsplit2.sv
// tb_wbsplit2: randomized scoreboard bench for wbsplit2 against a transaction-level model
module tb_wbsplit2;
    typedef struct { bit err; logic [31:0] data; int cyc; } exp_t;
    typedef struct { logic [31:0] d; bit e; } srsp_t;

    logic        clk = 0, rst_n = 0;
    logic        i_cyc = 0, i_stb = 0, i_we = 0;
    logic [31:0] i_adr = 0, i_dat = 0;
    logic [3:0]  i_sel = 0;
    logic        o_ack, o_stall, o_err;
    logic [31:0] o_data;
    logic        o_s0_cyc, o_s0_stb, o_s1_cyc, o_s1_stb;
    logic        i_s0_ack = 0, i_s0_stall = 0, i_s0_err = 0;
    logic        i_s1_ack = 0, i_s1_stall = 0, i_s1_err = 0;
    logic [31:0] i_s0_data = 0, i_s1_data = 0;
    logic        o_we;
    logic [31:0] o_adr, o_dat;
    logic [3:0]  o_sel;

    exp_t  sb[$];
    srsp_t sq[2][$];
    logic [1:0]  nx_ack = 0, nx_err = 0, nx_stall = 0;
    logic [31:0] nx_dat [2];
    logic [1:0]  ack_en = 2'b11;
    bit          stall_en = 0;
    int          cmp = 0, bad = 0, to_cnt = 0, cyc_n = 0;

    wbsplit2 dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
        .i_adr(i_adr), .i_dat(i_dat), .i_sel(i_sel),
        .o_ack(o_ack), .o_stall(o_stall), .o_err(o_err), .o_data(o_data),
        .o_s0_cyc(o_s0_cyc), .o_s0_stb(o_s0_stb), .i_s0_ack(i_s0_ack), .i_s0_stall(i_s0_stall),
        .i_s0_err(i_s0_err), .i_s0_data(i_s0_data),
        .o_s1_cyc(o_s1_cyc), .o_s1_stb(o_s1_stb), .i_s1_ack(i_s1_ack), .i_s1_stall(i_s1_stall),
        .i_s1_err(i_s1_err), .i_s1_data(i_s1_data),
        .o_we(o_we), .o_adr(o_adr), .o_dat(o_dat), .o_sel(o_sel)
    );

    always #5 clk = ~clk;

    // Address map as seen by the master: 0 = slave 0, 1 = slave 1, 2 = unmapped
    function automatic int tgt(input logic [31:0] a);
        if ((a & 32'hFFFF_F000) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_F000) == 32'h0000_1000) return 1;
        return 2;
    endfunction

    // Each slave answers with a data word derived from the address it saw
    function automatic logic [31:0] sdata(input int n, input logic [31:0] a);
        return a ^ (n == 0 ? 32'hC0DE_0000 : 32'h5A5A_0000);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        cmp++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc_n);
        end
    endtask

    // Monitor + scoreboard + slave models, all sampled mid-cycle
    initial begin
        exp_t  e;
        srsp_t r;
        int    t, out, last_t, to_seen;
        logic [1:0] s_cyc, s_stb, s_stall;
        last_t  = 0;
        to_seen = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (to_cnt != to_seen) begin
                to_seen = to_cnt;
                cmp++;
                bad++;
                $display("FAIL wait_bound: bound expired, got stalled want accepted (cycle %0d)", cyc_n);
            end
            s_cyc   = {o_s1_cyc, o_s0_cyc};
            s_stb   = {o_s1_stb, o_s0_stb};
            s_stall = {i_s1_stall, i_s0_stall};
            if (!rst_n) begin
                chk("reset_quiet", {o_s0_cyc, o_s0_stb, o_s1_cyc, o_s1_stb, o_ack, o_err, o_stall}, 0);
                sb.delete();
                sq[0].delete();
                sq[1].delete();
                nx_ack = 0; nx_err = 0; nx_stall = 0;
            end else begin
                out = sb.size();
                t   = tgt(i_adr);
                if (i_cyc && i_stb && out > 0 && (out == 8 || sb[$].err && sb[$].cyc >= 0 || t != last_t))
                    chk("stall_rule", o_stall, 1);
                if (s_stb != 0) chk("one_stb", s_stb, s_stb == 2'b11 ? 2'b00 : s_stb);
                if (o_ack || o_err) begin
                    if (sb.size() == 0) chk("unexpected_rsp", {o_ack, o_err}, 0);
                    else begin
                        e = sb.pop_front();
                        chk("rsp_kind", {o_ack, o_err}, e.err ? 2'b01 : 2'b10);
                        if (!e.err) chk("rsp_data", o_data, e.data);
                        if (e.cyc >= 0) chk("err_latency", cyc_n, e.cyc);
                    end
                end
                if (i_cyc && i_stb && !o_stall) begin
                    if (t == 2) begin
                        chk("unmapped_nostb", s_stb, 0);
                        sb.push_back('{1'b1, 32'h0, cyc_n + 1});
                    end else begin
                        chk("route_stb", s_stb, t == 0 ? 2'b01 : 2'b10);
                        sb.push_back('{i_adr[11:0] == 12'hEE0, sdata(t, i_adr), -1});
                    end
                    last_t = t;
                end
                for (int n = 0; n < 2; n++) begin
                    if (s_cyc[n] && s_stb[n] && !s_stall[n]) begin
                        chk("slave_tgt", 64'(tgt(o_adr)), 64'(n));
                        chk("pass_through", {o_we, o_adr, o_dat, o_sel}, {i_we, i_adr, i_dat, i_sel});
                        sq[n].push_back('{sdata(n, o_adr), o_adr[11:0] == 12'hEE0});
                    end
                    if (ack_en[n] && sq[n].size() > 0 && $urandom_range(0, 2) != 0) begin
                        r = sq[n].pop_front();
                        nx_ack[n] = !r.e;
                        nx_err[n] = r.e;
                        nx_dat[n] = r.d;
                    end else begin
                        nx_ack[n] = 0;
                        nx_err[n] = 0;
                        nx_dat[n] = $urandom;
                    end
                    nx_stall[n] = stall_en && $urandom_range(0, 3) == 0;
                end
            end
        end
    end

    // Apply slave responses just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_s0_ack = nx_ack[0]; i_s0_err = nx_err[0]; i_s0_stall = nx_stall[0]; i_s0_data = nx_dat[0];
            i_s1_ack = nx_ack[1]; i_s1_err = nx_err[1]; i_s1_stall = nx_stall[1]; i_s1_data = nx_dat[1];
        end
    end

    task automatic start(input logic [31:0] a);
        i_stb = 1;
        i_adr = a;
        i_we  = 1'($urandom_range(0, 1));
        i_dat = $urandom;
        i_sel = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_acc();
        int n = 0;
        do begin @(negedge clk); n++; end while (o_stall && n < 300);
        if (o_stall) to_cnt++;
        @(posedge clk);
        #1;
        i_stb = 0;
    endtask

    task automatic issue(input logic [31:0] a);
        start(a);
        wait_acc();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
        if (sb.size() != 0) to_cnt++;
        #1;
    endtask

    initial begin
        int          region;
        logic [31:0] a, off;
        nx_dat[0] = 0;
        nx_dat[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        i_cyc = 1;
        issue(32'h0000_0004);
        drain();
        issue(32'h0000_1000); issue(32'h0000_1004); issue(32'h0000_1008);
        drain();
        ack_en = 2'b01;
        issue(32'h0000_1010); issue(32'h0000_1014);
        start(32'h0000_0020);
        repeat (3) @(negedge clk);
        ack_en = 2'b11;
        wait_acc();
        drain();
        issue(32'h0000_8000);
        drain();
        issue(32'h0000_0EE0);
        drain();
        ack_en = 2'b01;
        for (int k = 0; k < 8; k++) issue(32'h0000_1000 | 32'(k * 4));
        start(32'h0000_1040);
        repeat (3) @(negedge clk);
        ack_en = 2'b11;
        wait_acc();
        drain();
        ack_en = 2'b00;
        issue(32'h0000_1100); issue(32'h0000_1104);
        @(posedge clk);
        #1;
        rst_n = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1;
        ack_en = 2'b11;
        issue(32'h0000_1108);
        drain();
        stall_en = 1;
        region   = 1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) region = $urandom_range(0, 9) == 0 ? 2 : int'($urandom_range(0, 1));
            off = 32'($urandom_range(0, 900)) << 2;
            a = region == 0 ? off : region == 1 ? (32'h0000_1000 | off) :
                ($urandom_range(0, 1) == 0 ? (32'h0000_8000 | off) : (32'hFFFF_0000 | off));
            issue(a);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        drain();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
